// File: rtl/cdc_req_arbiter.sv
// Arbitrates REQ_CNT master-domain requesters onto one CDC req/ack channel,
// keeping one transfer outstanding. Define CDC_ARB_FIXED_PRIO_EN for fixed priority.
module cdc_req_arbiter #(
  parameter int unsigned REQ_CNT = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = $clog2(REQ_CNT)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [REQ_CNT-1:0]        req_i,
  input  logic [REQ_CNT*DATA_W-1:0] data_i,
  output logic [REQ_CNT-1:0]        ack_o,
  output logic                      busy_o,
  output logic                      ch_req_o,
  input  logic                      ch_ack_i,
  output logic [DATA_W-1:0]         ch_data_o,
  output logic [ID_W-1:0]           ch_id_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [REQ_CNT-1:0]  ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                ch_req_q, ch_req_d;
  logic [DATA_W-1:0]   ch_data_q, ch_data_d;
  logic [ID_W-1:0]     ch_id_q, ch_id_d;

  logic [REQ_CNT-1:0]  elig;
  logic                win_vld;
  logic [ID_W-1:0]     win_id;
  logic [DATA_W-1:0]   win_data;

`ifndef CDC_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [REQ_CNT-1:0]  elig_rot;
  logic [ID_W:0]       win_ofs;
  logic [ID_W:0]       win_sum;
`endif

  // The acknowledged requester is masked for its ack cycle, so it cannot be
  // re-granted before it has had a chance to drop req_i.
  always_comb begin
    elig    = req_i & ~ack_q;
    win_vld = 1'b0;
    win_id  = '0;
`ifdef CDC_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < REQ_CNT; i++) begin
      if (!win_vld && elig[i]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(i);
      end
    end
`else
    // Rotate so rr_ptr sits at bit 0, find the first set bit, then undo the rotation.
    elig_rot = REQ_CNT'({elig, elig} >> rr_ptr_q);
    win_ofs  = '0;
    for (int unsigned i = 0; i < REQ_CNT; i++) begin
      if (!win_vld && elig_rot[i]) begin
        win_vld = 1'b1;
        win_ofs = (ID_W+1)'(i);
      end
    end
    win_sum = {1'b0, rr_ptr_q} + win_ofs;
    if (win_sum >= (ID_W+1)'(REQ_CNT)) begin
      win_sum = win_sum - (ID_W+1)'(REQ_CNT);
    end
    win_id = ID_W'(win_sum);
`endif
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < REQ_CNT; i++) begin
      if (ID_W'(i) == win_id) begin
        win_data = data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = '0;
    busy_d    = busy_q;
    ch_req_d  = 1'b0;
    ch_data_d = ch_data_q;
    ch_id_d   = ch_id_q;
`ifndef CDC_ARB_FIXED_PRIO_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          busy_d    = 1'b1;
          ch_req_d  = 1'b1;
          ch_id_d   = win_id;
          ch_data_d = win_data;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ch_ack_i) begin
          ack_d   = REQ_CNT'(1) << ch_id_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
`ifndef CDC_ARB_FIXED_PRIO_EN
          if (ch_id_q == ID_W'(REQ_CNT-1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = ch_id_q + ID_W'(1);
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      ch_req_q  <= 1'b0;
      ch_data_q <= '0;
      ch_id_q   <= '0;
`ifndef CDC_ARB_FIXED_PRIO_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      ch_req_q  <= ch_req_d;
      ch_data_q <= ch_data_d;
      ch_id_q   <= ch_id_d;
`ifndef CDC_ARB_FIXED_PRIO_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  assign ack_o     = ack_q;
  assign busy_o    = busy_q;
  assign ch_req_o  = ch_req_q;
  assign ch_data_o = ch_data_q;
  assign ch_id_o   = ch_id_q;

endmodule
